// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
//
// Scheduler for the RC4 brute-force key search. For every candidate key in
// [key_lo, key_hi] it runs the S-init, KSA and PRGA/decrypt engines in turn.
// All three engines share one single-port 256x8 S memory, and this block
// owns that memory. The decrypted stream is checked for plaintext validity:
// lowercase a..z or space, exactly MSG_LEN bytes. The search stops when a key
// passes (found) or when the range is used up (exhausted).
//
// Optional feature: define RC4_EARLY_ABORT_EN to abandon a candidate on its
// first illegal byte. The PRGA engine is told through prga_abort, and the
// scheduler does not wait for prga_done.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start                    one-cycle pulse, accepted only when not busy
//   key_lo, key_hi           inclusive key range, sampled on start
//   init/ksa/prga_start      one-cycle engine start pulses (Moore)
//   init/ksa/prga_done       one-cycle engine completion pulses
//   prga_abort               one-cycle early-abort pulse (0 unless enabled)
//   char_valid, char_data    decrypted byte stream from the PRGA engine
//   <eng>_addr/data/wren     per-engine S memory requests
//   mem_addr/data/wren       arbitrated S memory port
//   secret_key               current candidate key
//   busy, found, exhausted   status; found_key holds the passing key
//   state_dbg                current FSM state, for debug and checkers
//
// Handshake: all start, done and abort signals are single-cycle pulses with
// no back-pressure. A done pulse is acted on only in the matching *_WAIT
// state. char_valid marks exactly one byte per high cycle, and those bytes
// are examined only in PRGA_WAIT. Pulses that arrive in any other state are
// dropped.

module rc4_key_search_ctrl #(
  parameter int KEY_W   = 24,
  parameter int MSG_LEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_lo,
  input  logic [KEY_W-1:0] key_hi,
  output logic             init_start,
  output logic             ksa_start,
  output logic             prga_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             prga_done,
  output logic             prga_abort,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_data,
  input  logic             init_wren,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       ksa_data,
  input  logic             ksa_wren,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       prga_data,
  input  logic             prga_wren,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_data,
  output logic             mem_wren,
  output logic [KEY_W-1:0] secret_key,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key,
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_GO   = 4'd1;
  localparam logic [3:0] S_INIT_WAIT = 4'd2;
  localparam logic [3:0] S_KSA_GO    = 4'd3;
  localparam logic [3:0] S_KSA_WAIT  = 4'd4;
  localparam logic [3:0] S_PRGA_GO   = 4'd5;
  localparam logic [3:0] S_PRGA_WAIT = 4'd6;
  localparam logic [3:0] S_NEXT_KEY  = 4'd7;
  localparam logic [3:0] S_FOUND     = 4'd8;
  localparam logic [3:0] S_EXHAUSTED = 4'd9;

  localparam logic [5:0] MSG_LEN_C = 6'(MSG_LEN);

  logic [3:0]       state;
  logic [3:0]       next_state;
  logic [KEY_W-1:0] key_hi_q;
  logic             bad;
  logic [5:0]       char_cnt;

  logic             char_legal;
  logic             byte_bad;
  logic             bad_next;
  logic [5:0]       cnt_next;
  logic             msg_ok;
  logic             idle_like;
  logic             run;

  assign state_dbg = state;
  assign idle_like = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED);
  assign busy      = !idle_like;

  // Combinational outputs are gated by reset. While reset is high, the
  // engines lose the memory and see no start or abort pulses, even before
  // the state register has returned to IDLE.
  assign run = !reset;

  // Plaintext check. A byte that arrives together with prga_done is folded
  // into the pass/fail decision through bad_next and cnt_next.
  assign char_legal = ((char_data >= 8'd97) && (char_data <= 8'd122)) || (char_data == 8'd32);
  assign byte_bad   = char_valid && !char_legal;
  assign bad_next   = bad || byte_bad;
  assign cnt_next   = char_cnt + {5'd0, char_valid};
  assign msg_ok     = !bad_next && (cnt_next == MSG_LEN_C);

  assign init_start = run && (state == S_INIT_GO);
  assign ksa_start  = run && (state == S_KSA_GO);
  assign prga_start = run && (state == S_PRGA_GO);

`ifdef RC4_EARLY_ABORT_EN
  assign prga_abort = run && (state == S_PRGA_WAIT) && byte_bad;
`else
  assign prga_abort = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) next_state = (key_lo > key_hi) ? S_EXHAUSTED : S_INIT_GO;
      end
      S_INIT_GO:   next_state = S_INIT_WAIT;
      S_INIT_WAIT: if (init_done) next_state = S_KSA_GO;
      S_KSA_GO:    next_state = S_KSA_WAIT;
      S_KSA_WAIT:  if (ksa_done) next_state = S_PRGA_GO;
      S_PRGA_GO:   next_state = S_PRGA_WAIT;
      S_PRGA_WAIT: begin
`ifdef RC4_EARLY_ABORT_EN
        // The illegal byte wins over a prga_done in the same cycle.
        if (byte_bad)       next_state = S_NEXT_KEY;
        else if (prga_done) next_state = msg_ok ? S_FOUND : S_NEXT_KEY;
`else
        if (prga_done)      next_state = msg_ok ? S_FOUND : S_NEXT_KEY;
`endif
      end
      // The equality test comes before the increment, so an all-ones key_hi
      // ends the search instead of wrapping round to zero.
      S_NEXT_KEY:  next_state = (secret_key == key_hi_q) ? S_EXHAUSTED : S_INIT_GO;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      secret_key <= '0;
      found_key  <= '0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      key_hi_q   <= '0;
      bad        <= 1'b0;
      char_cnt   <= 6'd0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            found     <= 1'b0;
            found_key <= '0;
            key_hi_q  <= key_hi;
            if (key_lo > key_hi) exhausted <= 1'b1;
            else begin
              exhausted  <= 1'b0;
              secret_key <= key_lo;
            end
          end
        end
        S_PRGA_GO: begin
          bad      <= 1'b0;
          char_cnt <= 6'd0;
        end
        S_PRGA_WAIT: begin
          bad      <= bad_next;
          char_cnt <= cnt_next;
          if (next_state == S_FOUND) begin
            found     <= 1'b1;
            found_key <= secret_key;
          end
        end
        S_NEXT_KEY: begin
          if (secret_key == key_hi_q) exhausted <= 1'b1;
          else                        secret_key <= secret_key + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // S memory arbiter: the owner is decided by state alone.
  always_comb begin
    mem_addr = 8'd0;
    mem_data = 8'd0;
    mem_wren = 1'b0;
    if (run) begin
      case (state)
        S_INIT_GO, S_INIT_WAIT: begin
          mem_addr = init_addr;
          mem_data = init_data;
          mem_wren = init_wren;
        end
        S_KSA_GO, S_KSA_WAIT: begin
          mem_addr = ksa_addr;
          mem_data = ksa_data;
          mem_wren = ksa_wren;
        end
        S_PRGA_GO, S_PRGA_WAIT: begin
          mem_addr = prga_addr;
          mem_data = prga_data;
          mem_wren = prga_wren;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
module tb_rc4_key_search_ctrl;

  localparam int KEY_W   = 24;
  localparam int MSG_LEN = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [KEY_W-1:0] key_lo;
  logic [KEY_W-1:0] key_hi;
  logic             init_start, ksa_start, prga_start;
  logic             init_done, ksa_done, prga_done;
  logic             prga_abort;
  logic             char_valid;
  logic [7:0]       char_data;
  logic [7:0]       init_addr, init_data, ksa_addr, ksa_data, prga_addr, prga_data;
  logic             init_wren, ksa_wren, prga_wren;
  logic [7:0]       mem_addr, mem_data;
  logic             mem_wren;
  logic [KEY_W-1:0] secret_key;
  logic             busy, found, exhausted;
  logic [KEY_W-1:0] found_key;
  logic [3:0]       state_dbg;

  rc4_key_search_ctrl #(.KEY_W(KEY_W), .MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .key_lo(key_lo), .key_hi(key_hi),
    .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
    .prga_abort(prga_abort), .char_valid(char_valid), .char_data(char_data),
    .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .secret_key(secret_key), .busy(busy), .found(found), .exhausted(exhausted),
    .found_key(found_key), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected start pulses in order, {kind, key}. 1=init 2=ksa 3=prga.
  logic [KEY_W+1:0] exp_q[$];
  int               owner = 0;        // engine that must own the S memory
  logic             expect_abort = 1'b0;

  // Engines request the memory with random traffic on every cycle.
  initial begin
    init_addr = 8'd0; init_data = 8'd0; init_wren = 1'b0;
    ksa_addr  = 8'd0; ksa_data  = 8'd0; ksa_wren  = 1'b0;
    prga_addr = 8'd0; prga_data = 8'd0; prga_wren = 1'b0;
    forever begin
      @(posedge clk); #1;
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom);
      ksa_addr  = 8'($urandom); ksa_data  = 8'($urandom); ksa_wren  = 1'($urandom);
      prga_addr = 8'($urandom); prga_data = 8'($urandom); prga_wren = 1'($urandom);
    end
  end

  // ---------------- compare process (every cycle) ----------------
  int               cp_n;
  logic [1:0]       cp_kind;
  logic [KEY_W+1:0] cp_e;
  logic [16:0]      cp_mem;
  logic             cp_ab;

  always @(negedge clk) begin
    cp_n    = int'(init_start) + int'(ksa_start) + int'(prga_start);
    cp_kind = init_start ? 2'd1 : ksa_start ? 2'd2 : prga_start ? 2'd3 : 2'd0;
    if (cp_n > 1) begin
      checks++; errors++;
      $display("FAIL start_overlap got %0d pulses want 1", cp_n);
    end
    if (cp_n >= 1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected got kind %0d key %0h want none", cp_kind, secret_key);
      end else begin
        cp_e = exp_q.pop_front();
        if (cp_e !== {cp_kind, secret_key}) begin
          errors++;
          $display("FAIL start_seq got kind %0d key %0h want kind %0d key %0h",
                   cp_kind, secret_key, cp_e[KEY_W+1:KEY_W], cp_e[KEY_W-1:0]);
        end
      end
      owner = int'(cp_kind);
    end
    if (reset) owner = 0;
    case (owner)
      1:       cp_mem = {init_addr, init_data, init_wren};
      2:       cp_mem = {ksa_addr,  ksa_data,  ksa_wren};
      3:       cp_mem = {prga_addr, prga_data, prga_wren};
      default: cp_mem = 17'd0;
    endcase
    checks++;
    if ({mem_addr, mem_data, mem_wren} !== cp_mem) begin
      errors++;
      $display("FAIL mem_arb got %h want %h (owner %0d)", {mem_addr, mem_data, mem_wren}, cp_mem, owner);
    end
`ifdef RC4_EARLY_ABORT_EN
    cp_ab = expect_abort;
`else
    cp_ab = 1'b0;
`endif
    checks++;
    if (prga_abort !== cp_ab) begin
      errors++;
      $display("FAIL prga_abort got %b want %b", prga_abort, cp_ab);
    end
    // Ownership ends after the engine's done, an abort, or reset.
    if ((owner == 1 && init_done) || (owner == 2 && ksa_done) ||
        (owner == 3 && (prga_done || cp_ab)) || reset)
      owner = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_keys(input int lo, input int last);
    for (int k = lo; k <= last; k++) begin
      exp_q.push_back({2'd1, KEY_W'(k)});
      exp_q.push_back({2'd2, KEY_W'(k)});
      exp_q.push_back({2'd3, KEY_W'(k)});
    end
  endtask

  task automatic do_start(input logic [KEY_W-1:0] lo, input logic [KEY_W-1:0] hi);
    @(posedge clk); #1;
    key_lo = lo; key_hi = hi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for a start pulse; n = negedges waited.
  task automatic wait_start(input int kind, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      n++;
      if ((kind == 1 && init_start) || (kind == 2 && ksa_start) || (kind == 3 && prga_start))
        hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL start_timeout got no pulse want kind %0d", kind);
      n = -1;
    end
  endtask

  task automatic pulse_done(input int kind);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (kind == 1) init_done = 1'b1;
    if (kind == 2) ksa_done  = 1'b1;
    if (kind == 3) prga_done = 1'b1;
    @(posedge clk); #1;
    init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
  endtask

  // One candidate: init, KSA, then nbytes decrypted bytes (byte bad_idx is
  // 8'h41). Returns the wait for init_start in negedges.
  task automatic run_key(input int nbytes, input int bad_idx, input bit last_with_done,
                         output int n_init);
    int  n;
    bit  aborted;
    wait_start(1, n_init);
    pulse_done(1);
    wait_start(2, n);
    pulse_done(2);
    wait_start(3, n);
    aborted = 1'b0;
    for (int i = 0; i < nbytes && !aborted; i++) begin
      @(posedge clk); #1;
      if (i % 8 == 5) begin
        char_valid = 1'b0;
        @(posedge clk); #1;
      end
      char_valid = 1'b1;
      char_data  = (i == bad_idx) ? 8'h41 : ((i % 7 == 6) ? 8'd32 : 8'(97 + i % 26));
      prga_done  = last_with_done && (i == nbytes - 1);
`ifdef RC4_EARLY_ABORT_EN
      if (i == bad_idx) begin
        expect_abort = 1'b1;
        aborted = 1'b1;
      end
`endif
    end
    @(posedge clk); #1;
    char_valid = 1'b0; expect_abort = 1'b0;
    if (!aborted && !last_with_done) begin
      prga_done = 1'b1;
      @(posedge clk); #1;
    end
    prga_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int n_init;

  initial begin
    reset = 1'b1; start = 1'b0; key_lo = '0; key_hi = '0;
    init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
    char_valid = 1'b0; char_data = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_exhausted", 64'(exhausted), 64'd0);
    chk("rst_secret_key", 64'(secret_key), 64'd0);
    chk("rst_found_key", 64'(found_key), 64'd0);

    // Range 0..2, every key fails.
    push_keys(0, 2);
    do_start(24'd0, 24'd2);
    run_key(5, -1, 1'b0, n_init);
    chk("t1_first_latency", 64'(n_init), 64'd1);
    run_key(5, -1, 1'b0, n_init);
    chk("t1_key_overhead", 64'(n_init), 64'd2);
    run_key(5, -1, 1'b0, n_init);
    @(negedge clk);
    chk("t1_nextkey_busy", 64'(busy), 64'd1);
    chk("t1_nextkey_exh", 64'(exhausted), 64'd0);
    @(negedge clk);
    chk("t1_exhausted", 64'(exhausted), 64'd1);
    chk("t1_found", 64'(found), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_secret_key", 64'(secret_key), 64'd2);

    // Range 5..9, key 7 decrypts to legal text.
    push_keys(5, 7);
    do_start(24'd5, 24'd9);
    run_key(4, -1, 1'b0, n_init);
    run_key(4, -1, 1'b0, n_init);
    run_key(32, -1, 1'b0, n_init);
    @(negedge clk);
    chk("t2_found", 64'(found), 64'd1);
    chk("t2_found_key", 64'(found_key), 64'd7);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_exhausted", 64'(exhausted), 64'd0);
    repeat (10) @(negedge clk);
    chk("t2_found_hold", 64'(found), 64'd1);

    // Empty range: exhausted next cycle, no engine activity.
    do_start(24'd4, 24'd3);
    @(negedge clk);
    chk("t3_exhausted", 64'(exhausted), 64'd1);
    chk("t3_found_clr", 64'(found), 64'd0);
    chk("t3_found_key_clr", 64'(found_key), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);

    // Illegal byte 8'h41 as char 3 of key 10; key 11 ends with byte+done together.
    push_keys(10, 11);
    do_start(24'd10, 24'd11);
    run_key(6, 3, 1'b0, n_init);
    run_key(32, -1, 1'b1, n_init);
    chk("t4_after_bad_latency", 64'(n_init), 64'd2);
    @(negedge clk);
    chk("t4_found", 64'(found), 64'd1);
    chk("t4_found_key", 64'(found_key), 64'd11);

    // 31 bytes fails; illegal last byte alongside done fails; 32 bytes passes.
    push_keys(20, 22);
    do_start(24'd20, 24'd23);
    run_key(31, -1, 1'b0, n_init);
    run_key(32, 31, 1'b1, n_init);
    chk("t5_key21_latency", 64'(n_init), 64'd2);
    run_key(32, -1, 1'b0, n_init);
    chk("t5_key22_latency", 64'(n_init), 64'd2);
    @(negedge clk);
    chk("t5_found", 64'(found), 64'd1);
    chk("t5_found_key", 64'(found_key), 64'd22);

    // All-ones key_hi must not wrap.
    push_keys(24'hFFFFFF, 24'hFFFFFF);
    do_start(24'hFFFFFF, 24'hFFFFFF);
    run_key(3, -1, 1'b0, n_init);
    repeat (2) @(negedge clk);
    chk("t6_exhausted", 64'(exhausted), 64'd1);
    chk("t6_secret_key", 64'(secret_key), 64'hFFFFFF);
    repeat (5) @(negedge clk);

    // Reset during KSA_WAIT, then restart from key_lo.
    push_keys(30, 30);
    do_start(24'd30, 24'd40);
    wait_start(1, n_init);
    pulse_done(1);
    wait_start(2, n_init);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_mem_wren", 64'(mem_wren), 64'd0);
    chk("t7_secret_key", 64'(secret_key), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_keys(30, 30);
    do_start(24'd30, 24'd30);
    run_key(32, -1, 1'b0, n_init);
    chk("t7_restart_latency", 64'(n_init), 64'd1);
    @(negedge clk);
    chk("t7_found", 64'(found), 64'd1);
    chk("t7_found_key", 64'(found_key), 64'd30);
    repeat (5) @(negedge clk);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
